ps2_dir_decoder: RTL
====================

Name: ps2_dir_decoder

Overview:
- Sits between PS2_Interface and proc_skeleton.
- Turns the raw PS/2 set-2 scan-code byte stream (ps2_key_pressed strobe plus ps2_key_data byte) into registered per-player direction state and a pause toggle.
- Player 0 uses W/A/S/D; player 1 uses the extended arrow keys.
- Replaces the sw0–sw7 switch inputs as the direction source for the processor.

Parameters:
- TIMEOUT_CYCLES, 2500000: cycles a prefix state (E0/F0) may wait for its next byte before the FSM returns to IDLE (50 ms at 50 MHz).
- CNT_W, 22: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- ps2_key_pressed  in  1  one-cycle strobe, a new byte is valid on ps2_key_data
- ps2_key_data  in  8  received scan-code byte
- held0  out  4  player 0 held keys {left,down,right,up} = {A,S,D,W}
- held1  out  4  player 1 held keys {left,down,right,up} = {E0 6B, E0 72, E0 74, E0 75}
- dir0  out  3  player 0 active direction: 0 none, 1 up, 2 right, 3 down, 4 left
- dir1  out  3  player 1 active direction, same encoding
- paused  out  1  pause flag, toggled by P (0x4D)
- key_event  out  1  one-cycle pulse when any heldN or dirN bit changes

Behaviour:
- Reset (async, resetn=0): FSM=IDLE, counter=0. held0, held1, dir0, dir1, paused, key_event, and the internal P-held bit are all 0. Reset mid-sequence discards any partial prefix.
- Bytes are consumed only on cycles where ps2_key_pressed=1. Other cycles leave the state unchanged, except for the timeout counter.
- FSM states and transitions on a strobe:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> non-extended make event, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> extended make, then IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT_BRK; other -> non-extended break, then IDLE.
  - EXT_BRK: E0 or F0 -> stay; other -> extended break, then IDLE.
- Timeout:
  - Counter clears on every strobe and on entry to IDLE.
  - Counter increments each cycle while in EXT, BRK or EXT_BRK.
  - When it reaches TIMEOUT_CYCLES-1, FSM -> IDLE with no key event.
  - A strobe in the same cycle as the timeout wins: the byte is processed in the current state.
- Key mapping:
  - Non-extended: 1D=P0 up, 23=P0 right, 1B=P0 down, 1C=P0 left, 4D=P.
  - Extended: 75=P1 up, 74=P1 right, 72=P1 down, 6B=P1 left.
  - Any other code, and any mapped code carrying the wrong extension (e.g. keypad 75 without E0, or E0 1D), is ignored.
- Make event:
  - Sets the held bit.
  - If the key was not already held, dirN becomes that key.
  - A typematic repeat (make of an already-held key) changes nothing.
- Break event:
  - Clears the held bit.
  - If the released key equals dirN, dirN falls back to the remaining held keys in priority up > right > down > left, else 0.
  - If the released key is not dirN, dirN is unchanged.
  - A break of a key that is not held is a no-op.
- Pause:
  - A make of P while the P-held bit is 0 toggles paused and sets P-held.
  - A break of P clears P-held.
  - Repeats do not toggle.
  - key_event does not fire for pause.
- Latency: outputs update on the clock edge after the strobe carrying the final byte of a sequence, i.e. 1 cycle. All outputs are registered.
- key_event is high for exactly 1 cycle, coincident with the output change.
- Players are independent: a player 0 event never alters held1/dir1, and vice versa.

Test Plan:
- Reset, then strobe 1D -> next cycle held0=0001, dir0=1, key_event=1 for 1 cycle. Then F0,1D -> held0=0000, dir0=0.
- Strobe 1D then 23 (W then D held) -> held0=0011, dir0=2. Then F0,23 -> dir0=1. Repeat 1D five times -> no change, key_event stays 0.
- Strobe E0,6B -> held1=1000, dir1=4, held0 unchanged. Then E0,F0,6B -> held1=0000, dir1=0. Strobe 75 without E0 -> no change.
- Strobe 4D, 4D, 4D (typematic) -> paused=1, no further toggle. F0,4D then 4D -> paused=0.
- Strobe E0, then no strobe for TIMEOUT_CYCLES (bench override: 16) -> FSM back to IDLE. Then 75 -> ignored. Then E0,75 -> dir1=1.
- Strobe F0, assert resetn=0 for 2 cycles, release, strobe 1C -> treated as a make: held0=1000, dir0=4.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// PS/2 set-2 scan-code decoder: turns the byte stream into per-player held keys,
// an active direction per player, and a pause toggle.
module ps2_dir_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int CNT_W          = 22
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic [3:0] held0,
  output logic [3:0] held1,
  output logic [2:0] dir0,
  output logic [2:0] dir1,
  output logic       paused,
  output logic       key_event,
  output logic [1:0] fsm_state
);

  // Handshake: a byte is consumed exactly on cycles where ps2_key_pressed is 1;
  // there is no back-pressure, every strobed byte is taken.
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             p_held, p_held_n;
  logic             timeout_hit;
  logic             is_e0, is_f0, ev, ev_ext, ev_brk;
  logic             hit0, hit1, hit_p;
  logic [1:0]       idx;
  logic [3:0]       held0_n, held1_n;
  logic [2:0]       dir0_n, dir1_n;
  logic             paused_n, key_event_n;

  assign fsm_state   = state;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign is_e0       = (ps2_key_data == 8'hE0);
  assign is_f0       = (ps2_key_data == 8'hF0);
  assign ev          = ps2_key_pressed && !is_e0 && !is_f0;
  assign ev_ext      = (state == EXT) || (state == EXT_BRK);
  assign ev_brk      = (state == BRK) || (state == EXT_BRK);

  // Returns {held, dir} after a make/break of key idx (0 up, 1 right, 2 down, 3 left).
  function automatic logic [6:0] apply_key(input logic [3:0] held, input logic [2:0] dir,
                                           input logic brk, input logic [1:0] k);
    logic [3:0] h;
    logic [2:0] d;
    logic [2:0] key;
    h   = held;
    d   = dir;
    key = {1'b0, k} + 3'd1;
    if (!brk) begin
      if (!held[k]) begin
        h[k] = 1'b1;
        d    = key;
      end
    end else if (held[k]) begin
      h[k] = 1'b0;
      if (dir == key) begin
        if (h[0])      d = 3'd1;
        else if (h[1]) d = 3'd2;
        else if (h[2]) d = 3'd3;
        else if (h[3]) d = 3'd4;
        else           d = 3'd0;
      end
    end
    return {h, d};
  endfunction

  always_comb begin
    state_n = state;
    if (ps2_key_pressed) begin
      case (state)
        IDLE:    state_n = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
        EXT:     state_n = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
        BRK:     state_n = is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
        EXT_BRK: state_n = (is_e0 || is_f0) ? EXT_BRK : IDLE;
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && timeout_hit) begin
      state_n = IDLE;
    end
  end

  // A code only maps when its extension prefix matches the key table.
  always_comb begin
    hit0  = 1'b0;
    hit1  = 1'b0;
    hit_p = 1'b0;
    idx   = 2'd0;
    if (ev && !ev_ext) begin
      case (ps2_key_data)
        8'h1D:   begin hit0 = 1'b1; idx = 2'd0; end
        8'h23:   begin hit0 = 1'b1; idx = 2'd1; end
        8'h1B:   begin hit0 = 1'b1; idx = 2'd2; end
        8'h1C:   begin hit0 = 1'b1; idx = 2'd3; end
        8'h4D:   hit_p = 1'b1;
        default: ;
      endcase
    end else if (ev && ev_ext) begin
      case (ps2_key_data)
        8'h75:   begin hit1 = 1'b1; idx = 2'd0; end
        8'h74:   begin hit1 = 1'b1; idx = 2'd1; end
        8'h72:   begin hit1 = 1'b1; idx = 2'd2; end
        8'h6B:   begin hit1 = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end
  end

  always_comb begin
    {held0_n, dir0_n} = hit0 ? apply_key(held0, dir0, ev_brk, idx) : {held0, dir0};
    {held1_n, dir1_n} = hit1 ? apply_key(held1, dir1, ev_brk, idx) : {held1, dir1};
    paused_n = paused;
    p_held_n = p_held;
    if (hit_p) begin
      if (!ev_brk && !p_held) paused_n = !paused;
      p_held_n = !ev_brk;
    end
    key_event_n = (held0_n != held0) || (dir0_n != dir0) ||
                  (held1_n != held1) || (dir1_n != dir1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      held0     <= '0;
      held1     <= '0;
      dir0      <= '0;
      dir1      <= '0;
      paused    <= 1'b0;
      p_held    <= 1'b0;
      key_event <= 1'b0;
    end else begin
      state <= state_n;
      if (ps2_key_pressed || state == IDLE || timeout_hit) cnt <= '0;
      else                                                 cnt <= cnt + 1'b1;
      held0     <= held0_n;
      held1     <= held1_n;
      dir0      <= dir0_n;
      dir1      <= dir1_n;
      paused    <= paused_n;
      p_held    <= p_held_n;
      key_event <= key_event_n;
    end
  end

endmodule
